// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: state encoding, round count, RCON table,
// S-box and the word helpers used by both the forward and inverse key steps.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Round constant bytes; entry r sits at bits [8*r +: 8], entry 0 is unused.
  localparam logic [87:0] RCON_TBL = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  // AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // RCON word for round r (1..10); out-of-range rounds give zero.
  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r <= 4'd10) begin
      rc = RCON_TBL[8*r +: 8];
    end
    return {rc, 24'h0};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX_TBL[8*idx +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// One inverse AES-128 key-schedule step: round key r in, round key r-1 out.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] in_bus,
  input  logic [31:0]  rcon,
  output logic [127:0] out_bus
);

  logic [31:0] p0, p1, p2, p3;
  logic [31:0] q0, q1, q2, q3;

  // Words 1..3 undo the XOR chain first; word 0 then needs the recovered w3.
  always_comb begin
    {p0, p1, p2, p3} = in_bus;
    q3 = p3 ^ p2;
    q2 = p2 ^ p1;
    q1 = p1 ^ p0;
    q0 = p0 ^ rcon ^ sub_word(rot_word(q3));
    out_bus = {q0, q1, q2, q3};
  end

endmodule

// File: rtl/key_schedule.sv
// One forward AES-128 key-schedule step: round key r-1 in, round key r out.
module key_schedule
  import aes_pkg::*;
(
  input  logic [127:0] in_bus,
  input  logic [31:0]  rcon,
  output logic [127:0] out_bus
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;

  // Each new word chains off the freshly computed word before it.
  always_comb begin
    {w0, w1, w2, w3} = in_bus;
    n0 = w0 ^ sub_word(rot_word(w3)) ^ rcon;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    out_bus = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/inv_key_expand.sv
// Streams AES-128 round keys 10 down to 0 over a valid/ready interface.
// Build option AES_KEY_FWD_EN: in_bus is the cipher key and the schedule is
// first run forward for ten cycles; otherwise in_bus is round key 10.
module inv_key_expand
  import aes_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       in_bus,
  output logic [127:0]       out_bus,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_t               state_reg, state_next;
  logic [127:0]         key_reg, key_next;
  logic [ROUND_W-1:0]   round_reg, round_next;
  logic                 valid_reg, valid_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic [31:0]          inv_rcon;
  logic [127:0]         inv_key;

  assign inv_rcon = rcon_word(round_reg[3:0]);

  inv_key_step u_inv_step (
    .in_bus  (key_reg),
    .rcon    (inv_rcon),
    .out_bus (inv_key)
  );

`ifdef AES_KEY_FWD_EN
  logic [31:0]          fwd_rcon;
  logic [127:0]         fwd_key;

  // During FWD round_reg holds the index of the key currently in key_reg.
  assign fwd_rcon = rcon_word(round_reg[3:0] + 4'd1);

  key_schedule u_key_schedule (
    .in_bus  (key_reg),
    .rcon    (fwd_rcon),
    .out_bus (fwd_key)
  );
`endif

  // Next-state and next-output decode; registers hold their value by default.
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done_reg) begin
          key_next = in_bus;
`ifdef AES_KEY_FWD_EN
          state_next = FWD;
          round_next = '0;
          valid_next = 1'b0;
`else
          state_next = EMIT;
          round_next = ROUND_W'(NUM_ROUNDS);
          valid_next = 1'b1;
`endif
        end
      end
`ifdef AES_KEY_FWD_EN
      FWD: begin
        key_next   = fwd_key;
        round_next = round_reg + ROUND_W'(1);
        if (round_reg == ROUND_W'(NUM_ROUNDS - 1)) begin
          state_next = EMIT;
          valid_next = 1'b1;
        end
      end
`endif
      EMIT: begin
        if (out_ready) begin
          if (round_reg == '0) begin
            state_next = IDLE;
            valid_next = 1'b0;
            done_next  = 1'b1;
          end else begin
            key_next   = inv_key;
            round_next = round_reg - ROUND_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      round_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign out_bus   = key_reg;
  assign out_round = round_reg;
  assign out_valid = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
